multicycle_controller: RTL and testbench

//  Multi-cycle sequencer for the RV32I datapath (pc, pc_plus_4, instruction_memory,

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/instr_decoder.sv | 71 +++++++
 rtl/multicycle_controller.sv | 162 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU op encoding, opcodes and sequencer state types
package cpu_pkg;

  // ALU operation select, shared with the alu block
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } mc_state_t;

  // Datapath-facing view of the latched instruction; all-zero when nothing is in flight
  typedef struct packed {
    alu_op_t     alu_op;
    logic        use_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm;
  } mc_fields_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational RV32I ALU-op decoder (R-type and I-type)
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_t    alu_op_o,
  output logic       use_imm_o,
  output logic       legal_o
);

  logic is_op;
  logic is_imm;
  logic f7_base;

  assign is_op   = (opcode_i == OPC_OP);
  assign is_imm  = (opcode_i == OPC_OP_IMM);
  assign f7_base = (funct7_i == F7_BASE);

  // Map funct3/funct7 to an ALU op; illegal encodings report ADD with no immediate
  always_comb begin
    alu_op_o  = ALU_ADD;
    use_imm_o = 1'b0;
    legal_o   = 1'b0;
    if (is_op || is_imm) begin
      case (funct3_i)
        3'b000: begin
          if (is_imm || f7_base) begin
            legal_o  = 1'b1;
            alu_op_o = ALU_ADD;
          end else if (funct7_i == F7_ALT) begin
            legal_o  = 1'b1;
            alu_op_o = ALU_SUB;
          end
        end
        3'b111: begin
          legal_o  = is_imm || f7_base;
          alu_op_o = ALU_AND;
        end
        3'b110: begin
          legal_o  = is_imm || f7_base;
          alu_op_o = ALU_OR;
        end
        3'b100: begin
          legal_o  = is_imm || f7_base;
          alu_op_o = ALU_XOR;
        end
        3'b010: begin
          legal_o  = is_imm || f7_base;
          alu_op_o = ALU_SLT;
        end
        // Shifts carry funct7 in the immediate too, so both forms need the base value
        3'b001: begin
          legal_o  = f7_base;
          alu_op_o = ALU_SLL;
        end
        3'b101: begin
          legal_o  = f7_base;
          alu_op_o = ALU_SRL;
        end
        default: legal_o = 1'b0;
      endcase
      use_imm_o = is_imm && legal_o;
    end
    if (!legal_o) begin
      alu_op_o = ALU_ADD;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I sequencer; MC_ILLEGAL_TRAP_EN halts on illegal instructions
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned RETIRE_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [31:0]         instruction,
  output logic                pc_write,
  output logic                reg_write,
  output logic [2:0]          alu_op,
  output logic                use_imm,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [11:0]         imm,
  output logic                busy,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  // Counter holds 0..FETCH_TIMEOUT-1; reaching the last value without a handshake halts
  localparam int unsigned    TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((FETCH_TIMEOUT == 0) ? 0 : FETCH_TIMEOUT - 1);

  mc_state_t           state_q;
  mc_fields_t          fields_q;
  logic                legal_q;
  logic                imem_req_q;
  logic                pc_write_q;
  logic                reg_write_q;
  logic                busy_q;
  logic                halted_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [RETIRE_W-1:0] retired_q;

  alu_op_t dec_alu_op;
  logic    dec_use_imm;
  logic    dec_legal;
  logic    fetch_expired;

  // Decode straight from the memory word so the result is registered with the IR
  instr_decoder u_decoder (
    .opcode_i  (instruction[6:0]),
    .funct3_i  (instruction[14:12]),
    .funct7_i  (instruction[31:25]),
    .alu_op_o  (dec_alu_op),
    .use_imm_o (dec_use_imm),
    .legal_o   (dec_legal)
  );

  assign fetch_expired = (FETCH_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  // Sequencer: state plus every output registered on the transition into its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fields_q    <= '0;
      legal_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      to_cnt_q    <= '0;
      retired_q   <= '0;
    end else begin
      pc_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
            to_cnt_q   <= '0;
          end
        end
        FETCH: begin
          if (imem_ready) begin
            state_q    <= DECODE;
            imem_req_q <= 1'b0;
            legal_q    <= dec_legal;
            fields_q   <= '{alu_op:  dec_alu_op,
                            use_imm: dec_use_imm,
                            rs1:     instruction[19:15],
                            rs2:     instruction[24:20],
                            rd:      instruction[11:7],
                            imm:     instruction[31:20]};
          end else if (fetch_expired) begin
            state_q    <= HALT;
            imem_req_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        DECODE: begin
`ifdef MC_ILLEGAL_TRAP_EN
          if (!legal_q) begin
            state_q  <= HALT;
            fields_q <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q <= EXECUTE;
          end
`else
          state_q <= EXECUTE;
`endif
        end
        EXECUTE: begin
          state_q     <= WRITEBACK;
          pc_write_q  <= 1'b1;
          reg_write_q <= legal_q && (fields_q.rd != 5'd0);
          retired_q   <= retired_q + RETIRE_W'(1);
        end
        WRITEBACK: begin
          fields_q <= '0;
          if (start) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b1;
            to_cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q    <= IDLE;
          fields_q   <= '0;
          imem_req_q <= 1'b0;
          busy_q     <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign pc_write  = pc_write_q;
  assign reg_write = reg_write_q;
  assign alu_op    = fields_q.alu_op;
  assign use_imm   = fields_q.use_imm;
  assign rs1       = fields_q.rs1;
  assign rs2       = fields_q.rs2;
  assign rd        = fields_q.rd;
  assign imm       = fields_q.imm;
  assign busy      = busy_q;
  assign halted    = halted_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3;
  localparam logic [2:0] A_XOR = 3'd4, A_SLL = 3'd5, A_SRL = 3'd6, A_SLT = 3'd7;
  // ALU op indexed by funct3 (slot 3 is unused)
  localparam logic [23:0] OP_TAB = {A_AND, A_OR, A_SRL, A_XOR, 3'd0, A_SLT, A_SLL, A_ADD};

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] instruction;
  logic        pc_write;
  logic        reg_write;
  logic [2:0]  alu_op;
  logic        use_imm;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] imm;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_ret = 0;
  int wb_cyc  = 0;

  multicycle_controller #(.FETCH_TIMEOUT(15), .RETIRE_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_ready(imem_ready), .instruction(instruction),
    .pc_write(pc_write), .reg_write(reg_write), .alu_op(alu_op), .use_imm(use_imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .busy(busy), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {27'd0, imem_req, pc_write, reg_write, busy, halted};
  endfunction

  function automatic logic [31:0] flds();
    return {1'b0, alu_op, use_imm, rs1, rs2, rd, imm};
  endfunction

  // Reference decode: returns {legal, alu_op[2:0], use_imm}
  function automatic logic [4:0] ref_decode(input logic [31:0] w);
    logic [23:0] tab;
    logic [2:0]  f3, op;
    logic [6:0]  f7;
    bit          r_form, i_form, legal;
    tab    = OP_TAB;
    f3     = w[14:12];
    f7     = w[31:25];
    r_form = (w[6:0] == 7'b0110011);
    i_form = (w[6:0] == 7'b0010011);
    op     = tab[int'(f3)*3 +: 3];
    if (!(r_form || i_form) || f3 == 3'b011) legal = 0;
    else if (f3 == 3'b001 || f3 == 3'b101)  legal = (f7 == 7'd0);
    else if (i_form)                         legal = 1;
    else if (f7 == 7'd0)                     legal = 1;
    else if (f3 == 3'b000 && f7 == 7'b0100000) begin
      legal = 1;
      op    = A_SUB;
    end else legal = 0;
    if (!legal) op = A_ADD;
    return {legal, op, legal && i_form};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] iv, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {iv, s1, f3, d, 7'b0010011};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 5) begin
      w[6:0] = 7'b0110011;
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'd0;
        1:       w[31:25] = 7'b0100000;
        default: ;
      endcase
    end else if (k < 9) begin
      w[6:0] = 7'b0010011;
      if ($urandom_range(0, 1) == 1) w[31:25] = 7'd0;
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; imem_ready = 1'b0;
    #1;
    check("reset_ctl", ctl(), 32'd0);
    check("reset_fields", flds(), 32'd0);
    check("reset_retired", {16'd0, retired}, 32'd0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the negedge of the first FETCH cycle; leaves at the negedge after WRITEBACK
  // (or at the HALT cycle when an illegal word traps)
  task automatic run_instr(input logic [31:0] w, input int stall, input bit drop, output bit hlt);
    logic [4:0]  d;
    logic [31:0] ef;
    d   = ref_decode(w);
    ef  = {1'b0, d[3:1], d[0], w[19:15], w[24:20], w[11:7], w[31:20]};
    hlt = 0;
    for (int i = 0; i <= stall; i++) begin
      imem_ready  = (i == stall);
      instruction = (i == stall) ? w : $urandom;
      check("fetch_ctl", ctl(), 32'b10010);
      check("fetch_fields", flds(), 32'd0);
      @(negedge clk);
    end
    imem_ready  = 1'b0;
    instruction = $urandom;
    check("decode_ctl", ctl(), 32'b00010);
    check("decode_fields", flds(), ef);
    @(negedge clk);
`ifdef MC_ILLEGAL_TRAP_EN
    if (!d[4]) begin
      check("trap_ctl", ctl(), 32'b00001);
      check("trap_fields", flds(), 32'd0);
      check("trap_retired", {16'd0, retired}, exp_ret % 65536);
      hlt = 1;
      return;
    end
`endif
    if (drop) start = 1'b0;
    check("exec_ctl", ctl(), 32'b00010);
    check("exec_fields", flds(), ef);
    @(negedge clk);
    exp_ret++;
    wb_cyc = cyc;
    check("wb_ctl", ctl(), {27'd0, 1'b0, 1'b1, (d[4] && w[11:7] != 5'd0), 1'b1, 1'b0});
    check("wb_fields", flds(), ef);
    check("wb_retired", {16'd0, retired}, exp_ret % 65536);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check(tag, ctl(), 32'd0);
    check({tag, "_fields"}, flds(), 32'd0);
  endtask

  initial begin
    bit          h;
    int          t0;
    logic [31:0] w;
    reset = 1'b0; start = 1'b0; imem_ready = 1'b0; instruction = 32'd0;

    do_reset();

    // Back-to-back fixed program with ready tied high: strobes every 4 cycles
    start = 1'b1; t0 = cyc;
    @(negedge clk);
    run_instr(rtype(7'd0, 5'd5, 5'd6, 3'b000, 5'd7), 0, 0, h);
    check("t1_wb_cycle_1", wb_cyc - t0, 32'd4);
    run_instr(rtype(7'b0100000, 5'd8, 5'd9, 3'b000, 5'd10), 0, 0, h);
    check("t1_wb_cycle_2", wb_cyc - t0, 32'd8);
    run_instr(itype(12'd1, 5'd12, 3'b000, 5'd13), 0, 1, h);
    check("t1_wb_cycle_3", wb_cyc - t0, 32'd12);
    check_idle("t1_idle");

    // Stalled second fetch, then a write to x0
    start = 1'b1;
    @(negedge clk);
    run_instr(rtype(7'd0, 5'd1, 5'd2, 3'b111, 5'd3), 0, 0, h);
    run_instr(itype(12'hFFF, 5'd4, 3'b100, 5'd5), 3, 0, h);
    run_instr(rtype(7'd0, 5'd2, 5'd1, 3'b000, 5'd0), 0, 1, h);
    check_idle("t2_idle");

    // Illegal all-zero word as the fourth instruction
    do_reset();
    start = 1'b1;
    @(negedge clk);
    run_instr(rtype(7'd0, 5'd1, 5'd2, 3'b110, 5'd3), 0, 0, h);
    run_instr(itype(12'd7, 5'd4, 3'b010, 5'd5), 1, 0, h);
    run_instr(itype(12'h025, 5'd6, 3'b101, 5'd7), 0, 0, h);
    run_instr(32'd0, 0, 1, h);
`ifdef MC_ILLEGAL_TRAP_EN
    check("t4_retired", {16'd0, retired}, 32'd3);
`else
    check("t4_retired", {16'd0, retired}, 32'd4);
`endif

    // Random programs with random fetch stalls
    for (int p = 0; p < 8; p++) begin
      do_reset();
      start = 1'b1;
      @(negedge clk);
      h = 0;
      for (int k = 0; k < 6 && !h; k++) begin
        w = gen_word();
        run_instr(w, $urandom_range(0, 4), (k == 5), h);
      end
      if (!h) check_idle("rand_idle");
    end

    // Fetch timeout: 15 FETCH cycles without ready, then sticky HALT
    do_reset();
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      check("to_fetch_ctl", ctl(), 32'b10010);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      check("to_halt_ctl", ctl(), 32'b00001);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    check("to_retired", {16'd0, retired}, 32'd0);

    // Asynchronous reset during EXECUTE of the second instruction
    do_reset();
    start = 1'b1;
    @(negedge clk);
    run_instr(rtype(7'd0, 5'd3, 5'd4, 3'b001, 5'd9), 0, 0, h);
    imem_ready = 1'b1; instruction = rtype(7'd0, 5'd1, 5'd2, 3'b000, 5'd6);
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    check("r6_exec_ctl", ctl(), 32'b00010);
    #2 reset = 1'b0;
    #1;
    check("r6_async_ctl", ctl(), 32'd0);
    check("r6_async_fields", flds(), 32'd0);
    check("r6_async_retired", {16'd0, retired}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    check_idle("r6_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("r6_after");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
